// File: rtl/gbc_mem_pkg.sv
// Shared types, constants and helpers for the banked work-RAM window.
package gbc_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RDATA = 2'd2
  } mem_state_t;

  localparam logic [7:0]  FILL_DEFAULT = 8'hEE;
  localparam logic [15:0] SVBK_ADDR    = 16'hFF70;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_bank_decode.sv
// Address decode for the two-window banked memory: window hit, bank-register
// hit and flat array index.
module mem_bank_decode
  import gbc_mem_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = 16'hC000,
  parameter int          BANK_SIZE     = 4096,
  parameter int          NUM_BANKS     = 8,
  parameter logic [15:0] BANK_REG_ADDR = SVBK_ADDR,
  localparam int         BW            = clog2(NUM_BANKS),
  localparam int         AW            = clog2(BANK_SIZE),
  localparam int         IW            = BW + AW
) (
  input  logic [15:0]   addr,
  input  logic [BW-1:0] bank_reg,
  output logic          hit,
  output logic          reg_hit,
  output logic [IW-1:0] index
);

  logic [16:0]   offset_s;
  logic          win0_s;
  logic          win1_s;
  logic [BW-1:0] eff_bank_s;
  logic [BW-1:0] sel_bank_s;

  always_comb begin
    offset_s   = {1'b0, addr} - {1'b0, BASE_ADDR};
    win0_s     = (addr >= BASE_ADDR) && (offset_s < 17'(BANK_SIZE));
    win1_s     = (addr >= BASE_ADDR) && (offset_s >= 17'(BANK_SIZE)) &&
                 (offset_s < 17'(2 * BANK_SIZE));
    // Bank 0 is permanently mapped low, so selecting it upstairs aliases to 1.
    eff_bank_s = (bank_reg == {BW{1'b0}}) ? BW'(32'd1) : bank_reg;
    sel_bank_s = win0_s ? {BW{1'b0}} : eff_bank_s;
    reg_hit    = (addr == BANK_REG_ADDR);
    hit        = (win0_s || win1_s) && !reg_hit;
    index      = {sel_bank_s, addr[AW-1:0]};
  end

endmodule

// File: rtl/banked_mem.sv
// Bank-switched work-RAM with sequential clear engine and registered reads on a
// shared tri-state bus. Optional per-byte parity: define GBC_MEM_PARITY_EN.
module banked_mem
  import gbc_mem_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = 16'hC000,
  parameter int          BANK_SIZE     = 4096,
  parameter int          NUM_BANKS     = 8,
  parameter logic [15:0] BANK_REG_ADDR = SVBK_ADDR,
  parameter logic [7:0]  FILL          = FILL_DEFAULT,
  localparam int         BW            = clog2(NUM_BANKS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [15:0]   addr_ext,
  inout  wire  [7:0]    data_ext,
  input  logic          mem_we,
  input  logic          mem_re,
  output logic          ready,
  output logic          busy,
  output logic [BW-1:0] bank,
  output logic          parity_err
);

  localparam int AW    = clog2(BANK_SIZE);
  localparam int IW    = BW + AW;
  localparam int DEPTH = NUM_BANKS * BANK_SIZE;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

`ifdef GBC_MEM_PARITY_EN
  localparam int WW = 9;
  function automatic logic [WW-1:0] encode_word(input logic [7:0] d);
    return {even_parity(d), d};
  endfunction
`else
  localparam int WW = 8;
  function automatic logic [WW-1:0] encode_word(input logic [7:0] d);
    return d;
  endfunction
`endif

  mem_state_t    state_q, state_d;
  logic [IW-1:0] clear_ptr_q, clear_ptr_d;
  logic [BW-1:0] bank_reg_q, bank_reg_d;
  logic [7:0]    rdata_q, rdata_d;

  logic          dec_hit_s;
  logic          dec_reg_hit_s;
  logic [IW-1:0] dec_index_s;

  logic          mem_wr_en_s;
  logic [IW-1:0] mem_wr_idx_s;
  logic [WW-1:0] mem_wr_word_s;
  logic [WW-1:0] rd_word_s;
  logic [WW-1:0] mem_q [DEPTH];

`ifdef GBC_MEM_PARITY_EN
  logic          parity_err_q, parity_err_d;
`endif

  mem_bank_decode #(
    .BASE_ADDR     (BASE_ADDR),
    .BANK_SIZE     (BANK_SIZE),
    .NUM_BANKS     (NUM_BANKS),
    .BANK_REG_ADDR (BANK_REG_ADDR)
  ) u_decode (
    .addr     (addr_ext),
    .bank_reg (bank_reg_q),
    .hit      (dec_hit_s),
    .reg_hit  (dec_reg_hit_s),
    .index    (dec_index_s)
  );

  assign rd_word_s = mem_q[dec_index_s];

  // Next-state, array write port and read-latch selection.
  always_comb begin
    state_d       = state_q;
    clear_ptr_d   = clear_ptr_q;
    bank_reg_d    = bank_reg_q;
    rdata_d       = rdata_q;
    mem_wr_en_s   = 1'b0;
    mem_wr_idx_s  = dec_index_s;
    mem_wr_word_s = encode_word(data_ext);
`ifdef GBC_MEM_PARITY_EN
    parity_err_d  = parity_err_q;
`endif
    case (state_q)
      CLEAR: begin
        mem_wr_en_s   = 1'b1;
        mem_wr_idx_s  = clear_ptr_q;
        mem_wr_word_s = encode_word(FILL);
        if (clear_ptr_q == LAST_IDX) begin
          clear_ptr_d = {IW{1'b0}};
          state_d     = IDLE;
        end else begin
          clear_ptr_d = clear_ptr_q + IW'(32'd1);
        end
      end
      IDLE: begin
        if (mem_we) begin
          if (dec_reg_hit_s) begin
            bank_reg_d = data_ext[BW-1:0];
          end else begin
            mem_wr_en_s = dec_hit_s;
          end
        end else if (mem_re && dec_reg_hit_s) begin
          rdata_d = {{(8 - BW){1'b1}}, bank_reg_q};
          state_d = RDATA;
        end else if (mem_re && dec_hit_s) begin
          rdata_d = rd_word_s[7:0];
          state_d = RDATA;
`ifdef GBC_MEM_PARITY_EN
          // Stored words carry even parity, so a clean word XORs to zero.
          if (^rd_word_s) begin
            parity_err_d = 1'b1;
          end else begin
            parity_err_d = parity_err_q;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Control state; reset restarts the clear engine from index 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      clear_ptr_q  <= {IW{1'b0}};
      bank_reg_q   <= {BW{1'b0}};
      rdata_q      <= 8'h00;
`ifdef GBC_MEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      bank_reg_q   <= bank_reg_d;
      rdata_q      <= rdata_d;
`ifdef GBC_MEM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage array carries no reset; contents are set by the clear engine.
  always_ff @(posedge clock) begin
    if (mem_wr_en_s) begin
      mem_q[mem_wr_idx_s] <= mem_wr_word_s;
    end
  end

  assign ready    = (state_q == RDATA);
  assign busy     = (state_q == CLEAR);
  assign bank     = (bank_reg_q == {BW{1'b0}}) ? BW'(32'd1) : bank_reg_q;
  assign data_ext = ((state_q == RDATA) && mem_re) ? rdata_q : 8'hzz;

`ifdef GBC_MEM_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_banked_mem.sv
// Randomised bench for banked_mem against a flat-array reference model.
module tb_banked_mem;

  localparam int          BS   = 16;
  localparam int          NB   = 4;
  localparam logic [15:0] BASE = 16'hC000;
  localparam logic [15:0] REG  = 16'hFF70;
  localparam logic [7:0]  FILLV = 8'hEE;
  localparam logic [7:0]  FLOAT = 8'hFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr_ext = 16'h0000;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic        ready;
  logic        busy;
  logic [1:0]  bank;
  logic        parity_err;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_val = 8'h00;
  tri1  [7:0]  data_ext;

  assign data_ext = drv_en ? drv_val : 8'hzz;

  banked_mem #(
    .BASE_ADDR     (BASE),
    .BANK_SIZE     (BS),
    .NUM_BANKS     (NB),
    .BANK_REG_ADDR (REG),
    .FILL          (FILLV)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .addr_ext   (addr_ext),
    .data_ext   (data_ext),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .ready      (ready),
    .busy       (busy),
    .bank       (bank),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] model_mem [NB*BS];
  int         model_bank;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_index(input logic [15:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (a == REG) return -1;
    if (off >= 0 && off < BS) return off;
    if (off >= BS && off < 2*BS) return ((model_bank == 0) ? 1 : model_bank) * BS + off - BS;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB*BS; i++) model_mem[i] = FILLV;
    model_bank = 0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    int idx;
    idx = model_index(a);
    if (a == REG) model_bank = int'(d) % NB;
    else if (idx >= 0) model_mem[idx] = d;
  endtask

  task automatic model_read(input logic [15:0] a, output logic valid, output logic [7:0] v);
    int idx;
    idx = model_index(a);
    valid = 1'b1;
    v = FLOAT;
    if (a == REG) v = 8'hFC | 8'(model_bank);
    else if (idx >= 0) v = model_mem[idx];
    else valid = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addr_ext = a; drv_val = d; drv_en = 1'b1; mem_we = 1'b1;
    @(negedge clock);
    mem_we = 1'b0; drv_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input string tag, input logic [15:0] a);
    logic       valid;
    logic [7:0] exp;
    model_read(a, valid, exp);
    @(negedge clock);
    addr_ext = a; mem_re = 1'b1;
    @(negedge clock);
    check_eq({tag, "_ready"}, ready, valid);
    check_eq({tag, "_data"}, data_ext, valid ? exp : FLOAT);
    mem_re = 1'b0;
  endtask

  task automatic bus_wr_rd(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addr_ext = a; drv_val = d; drv_en = 1'b1; mem_we = 1'b1; mem_re = 1'b1;
    @(negedge clock);
    check_eq("we_re_ready", ready, 1'b0);
    mem_we = 1'b0; mem_re = 1'b0; drv_en = 1'b0;
    model_write(a, d);
  endtask

  // Called at the moment reset is released; counts busy samples, one per clock.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
    check_eq(tag, n, 64);
    check_eq({tag, "_perr"}, parity_err, 1'b0);
  endtask

  function automatic logic [15:0] pick_win_addr();
    return BASE + 16'($urandom_range(0, 2*BS - 1));
  endfunction

  function automatic logic [15:0] pick_miss_addr();
    logic [15:0] m [4];
    m[0] = 16'hB000; m[1] = BASE - 16'd1; m[2] = BASE + 16'(2*BS); m[3] = REG + 16'd1;
    return m[$urandom_range(0, 3)];
  endfunction

  initial begin
    model_reset();
    #12;
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_ready", ready, 1'b0);
    check_eq("rst_bank", bank, 2'd1);
    check_eq("rst_perr", parity_err, 1'b0);
    check_eq("rst_bus", data_ext, FLOAT);
    @(negedge clock);
    reset_n = 1'b1;
    wait_clear("clear_len");

    for (int i = 0; i < 2*BS; i++) bus_read("fill", BASE + 16'(i));

    bus_write(16'hC003, 8'h5A);
    bus_read("rd_c003", 16'hC003);

    bus_write(REG, 8'h02);
    bus_write(16'hC011, 8'hA2);
    bus_write(REG, 8'h03);
    check_eq("bank3", bank, 2'd3);
    bus_read("bank3_rd", 16'hC011);
    bus_write(REG, 8'h02);
    bus_read("bank2_rd", 16'hC011);

    bus_write(REG, 8'h00);
    check_eq("bank0_alias", bank, 2'd1);
    bus_read("reg_rd", REG);

    bus_wr_rd(16'hC005, 8'h77);
    bus_read("after_wr_rd", 16'hC005);
    bus_read("miss_b000", 16'hB000);

    // Request dropped while the data is on the bus: ready holds, bus releases.
    @(negedge clock);
    addr_ext = 16'hC003; mem_re = 1'b1;
    @(negedge clock);
    mem_re = 1'b0;
    #1;
    check_eq("re_drop_ready", ready, 1'b1);
    check_eq("re_drop_bus", data_ext, FLOAT);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: bus_write(pick_win_addr(), 8'($urandom));
        3, 4, 5: bus_read("rand_rd", pick_win_addr());
        6:       bus_write(REG, 8'($urandom));
        7:       bus_read("rand_reg", REG);
        8:       if ($urandom_range(0, 1) == 0) bus_read("rand_miss", pick_miss_addr());
                 else bus_write(pick_miss_addr(), 8'($urandom));
        default: bus_wr_rd(pick_win_addr(), 8'($urandom));
      endcase
    end

    for (int b = 0; b < NB; b++) begin
      bus_write(REG, 8'(b));
      check_eq("sweep_bank", bank, (b == 0) ? 2'd1 : 2'(b));
      for (int i = BS; i < 2*BS; i++) bus_read("sweep", BASE + 16'(i));
    end
    check_eq("perr_mid", parity_err, 1'b0);

    // Reset during the clear engine run.
    bus_write(16'hC001, 8'h11);
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    model_reset();
    repeat (30) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midclr_busy", busy, 1'b1);
    check_eq("midclr_ready", ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_clear("midclr_len");

    // Reset while read data is on the bus.
    bus_write(16'hC007, 8'h3C);
    @(negedge clock);
    addr_ext = 16'hC007; mem_re = 1'b1;
    @(negedge clock);
    check_eq("midrd_ready_pre", ready, 1'b1);
    check_eq("midrd_data_pre", data_ext, 8'h3C);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrd_ready", ready, 1'b0);
    check_eq("midrd_busy", busy, 1'b1);
    check_eq("midrd_bus", data_ext, FLOAT);
    mem_re = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    wait_clear("midrd_len");
    check_eq("post_rst_bank", bank, 2'd1);
    bus_read("post_rst_c007", 16'hC007);
    bus_read("post_rst_c001", 16'hC001);
    bus_read("post_rst_c01f", 16'hC01F);
    check_eq("perr_end", parity_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
